// File: rtl/spi_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder_if
// Byte-level link between the SPI slave shifter and the command decoder.
//   rx_byte  : received MOSI byte (shifter -> decoder)
//   rx_valid : one-cycle strobe, rx_byte valid (shifter -> decoder)
//   tx_byte  : byte to preload into the MISO shifter (decoder -> shifter)
//   tx_load  : one-cycle strobe, tx_byte updated (decoder -> shifter)
// Modports: master = shifter side, slave = decoder side.
// ---------------------------------------------------------------------------
interface spi_cmd_decoder_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_load;

    modport master (output rx_byte, output rx_valid, input tx_byte, input tx_load);
    modport slave  (input rx_byte, input rx_valid, output tx_byte, output tx_load);
endinterface

// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
// Decodes one-byte-per-frame SPI commands into pitch/yaw PWM duty and
// direction registers, returns snapshotted encoder counts as MISO bytes and
// issues a soft-reset pulse.
//
// Ports:
//   clk, rst_n            : system clock, asynchronous active-low reset
//   io_spi (slave)        : rx_byte/rx_valid in, tx_byte/tx_load out
//   i_pitch_count         : pitch encoder count (CNT_W bits)
//   i_yaw_count           : yaw encoder count (CNT_W bits)
//   o_pitch_duty/o_pitch_dir, o_yaw_duty/o_yaw_dir : motor controls
//   o_soft_reset          : one-cycle pulse on 0xFF opcode
//   o_cmd_error           : sticky, set by an unknown opcode
//   o_busy                : high while a command is in progress
//
// Optional feature macro: DUTY_CLAMP_EN
//   defined   -> committed duty values above MAX_DUTY are written as MAX_DUTY
//   undefined -> committed duty values are written unmodified
// ---------------------------------------------------------------------------
module spi_cmd_decoder #(
    parameter int unsigned DUTY_W   = 16,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [15:0] MAX_DUTY = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_cmd_decoder_if.slave  io_spi,
    input  logic [CNT_W-1:0]  i_pitch_count,
    input  logic [CNT_W-1:0]  i_yaw_count,
    output logic [DUTY_W-1:0] o_pitch_duty,
    output logic              o_pitch_dir,
    output logic [DUTY_W-1:0] o_yaw_duty,
    output logic              o_yaw_dir,
    output logic              o_soft_reset,
    output logic              o_cmd_error,
    output logic              o_busy
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_P_DIR, S_P_HI, S_P_LO,
        S_Y_DIR, S_Y_HI, S_Y_LO, S_GET_HI, S_GET_LO
    } state_t;

    state_t            r_state,      w_state_nx;
    logic [TW-1:0]     r_tmo,        w_tmo_nx;
    logic [15:0]       r_shadow,     w_shadow_nx;
    logic              r_stg_dir,    w_stg_dir_nx;
    logic [7:0]        r_stg_hi,     w_stg_hi_nx;
    logic [7:0]        r_tx_byte,    w_tx_byte_nx;
    logic              r_tx_load,    w_tx_load_nx;
    logic [DUTY_W-1:0] r_pitch_duty, w_pitch_duty_nx;
    logic              r_pitch_dir,  w_pitch_dir_nx;
    logic [DUTY_W-1:0] r_yaw_duty,   w_yaw_duty_nx;
    logic              r_yaw_dir,    w_yaw_dir_nx;
    logic              r_soft_reset, w_soft_reset_nx;
    logic              r_cmd_error,  w_cmd_error_nx;

    logic [15:0]       w_pitch_ext;
    logic [15:0]       w_yaw_ext;
    logic [15:0]       w_commit;
    logic [DUTY_W-1:0] w_duty;

    assign w_pitch_ext = 16'(i_pitch_count);
    assign w_yaw_ext   = 16'(i_yaw_count);
    assign w_commit    = {r_stg_hi, io_spi.rx_byte};

    // Duty written at commit: truncated to DUTY_W, optionally clamped.
    always_comb begin
        w_duty = w_commit[DUTY_W-1:0];
`ifdef DUTY_CLAMP_EN
        if (16'(w_commit[DUTY_W-1:0]) > MAX_DUTY)
            w_duty = MAX_DUTY[DUTY_W-1:0];
`endif
    end

    always_comb begin
        w_state_nx      = r_state;
        w_tmo_nx        = r_tmo;
        w_shadow_nx     = r_shadow;
        w_stg_dir_nx    = r_stg_dir;
        w_stg_hi_nx     = r_stg_hi;
        w_tx_byte_nx    = r_tx_byte;
        w_tx_load_nx    = 1'b0;
        w_pitch_duty_nx = r_pitch_duty;
        w_pitch_dir_nx  = r_pitch_dir;
        w_yaw_duty_nx   = r_yaw_duty;
        w_yaw_dir_nx    = r_yaw_dir;
        w_soft_reset_nx = 1'b0;
        w_cmd_error_nx  = r_cmd_error;

        if (io_spi.rx_valid) begin
            // A byte always wins over a simultaneous timeout expiry.
            w_tmo_nx = '0;
            case (r_state)
                S_IDLE: begin
                    case (io_spi.rx_byte)
                        8'hFF: begin
                            w_soft_reset_nx = 1'b1;
                            w_pitch_duty_nx = '0;
                            w_pitch_dir_nx  = 1'b0;
                            w_yaw_duty_nx   = '0;
                            w_yaw_dir_nx    = 1'b0;
                            w_cmd_error_nx  = 1'b0;
                        end
                        8'h11: w_state_nx = S_P_DIR;
                        8'h21: w_state_nx = S_Y_DIR;
                        8'h12: begin
                            w_shadow_nx  = w_pitch_ext;
                            w_tx_byte_nx = w_pitch_ext[15:8];
                            w_tx_load_nx = 1'b1;
                            w_state_nx   = S_GET_HI;
                        end
                        8'h22: begin
                            w_shadow_nx  = w_yaw_ext;
                            w_tx_byte_nx = w_yaw_ext[15:8];
                            w_tx_load_nx = 1'b1;
                            w_state_nx   = S_GET_HI;
                        end
                        8'h00: ;
                        default: w_cmd_error_nx = 1'b1;
                    endcase
                end
                S_P_DIR: begin
                    w_stg_dir_nx = io_spi.rx_byte[0];
                    w_state_nx   = S_P_HI;
                end
                S_Y_DIR: begin
                    w_stg_dir_nx = io_spi.rx_byte[0];
                    w_state_nx   = S_Y_HI;
                end
                S_P_HI: begin
                    w_stg_hi_nx = io_spi.rx_byte;
                    w_state_nx  = S_P_LO;
                end
                S_Y_HI: begin
                    w_stg_hi_nx = io_spi.rx_byte;
                    w_state_nx  = S_Y_LO;
                end
                S_P_LO: begin
                    w_pitch_duty_nx = w_duty;
                    w_pitch_dir_nx  = r_stg_dir;
                    w_state_nx      = S_IDLE;
                end
                S_Y_LO: begin
                    w_yaw_duty_nx = w_duty;
                    w_yaw_dir_nx  = r_stg_dir;
                    w_state_nx    = S_IDLE;
                end
                S_GET_HI: begin
                    w_tx_byte_nx = r_shadow[7:0];
                    w_tx_load_nx = 1'b1;
                    w_state_nx   = S_GET_LO;
                end
                S_GET_LO: begin
                    w_tx_byte_nx = 8'h00;
                    w_tx_load_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_tmo == TMO_LAST) begin
                w_state_nx   = S_IDLE;
                w_tmo_nx     = '0;
                w_stg_dir_nx = 1'b0;
                w_stg_hi_nx  = '0;
                w_tx_byte_nx = 8'h00;
                w_tx_load_nx = 1'b1;
            end else begin
                w_tmo_nx = r_tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_shadow     <= '0;
            r_stg_dir    <= 1'b0;
            r_stg_hi     <= '0;
            r_tx_byte    <= '0;
            r_tx_load    <= 1'b0;
            r_pitch_duty <= '0;
            r_pitch_dir  <= 1'b0;
            r_yaw_duty   <= '0;
            r_yaw_dir    <= 1'b0;
            r_soft_reset <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_tmo        <= w_tmo_nx;
            r_shadow     <= w_shadow_nx;
            r_stg_dir    <= w_stg_dir_nx;
            r_stg_hi     <= w_stg_hi_nx;
            r_tx_byte    <= w_tx_byte_nx;
            r_tx_load    <= w_tx_load_nx;
            r_pitch_duty <= w_pitch_duty_nx;
            r_pitch_dir  <= w_pitch_dir_nx;
            r_yaw_duty   <= w_yaw_duty_nx;
            r_yaw_dir    <= w_yaw_dir_nx;
            r_soft_reset <= w_soft_reset_nx;
            r_cmd_error  <= w_cmd_error_nx;
        end
    end

    assign io_spi.tx_byte = r_tx_byte;
    assign io_spi.tx_load = r_tx_load;
    assign o_pitch_duty   = r_pitch_duty;
    assign o_pitch_dir    = r_pitch_dir;
    assign o_yaw_duty     = r_yaw_duty;
    assign o_yaw_dir      = r_yaw_dir;
    assign o_soft_reset   = r_soft_reset;
    assign o_cmd_error    = r_cmd_error;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Byte-level command decoder between the SPI slave shifter and the motor/encoder datapath in toplevel.
- Consumes 8-bit MOSI bytes (MSB-first, one per CS frame) and updates pitch/yaw PWM duty and direction registers.
- Snapshots quadrature encoder counts and returns them as MISO bytes.
- Issues a soft-reset pulse to the rest of the design.

Parameters:
DUTY_W, 16, width of duty outputs (<=16); lower DUTY_W bits of {hi,lo} are kept
CNT_W, 16, width of encoder count inputs (<=16); zero-extended to 16 for readback
TIMEOUT, 1024, clk cycles without rx_valid before an unfinished command is aborted
MAX_DUTY, 16'hFFFF, clamp ceiling (used only with DUTY_CLAMP_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  received MOSI byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  byte to preload into the MISO shifter
tx_load  out  1  one-cycle strobe, tx_byte updated
pitch_count  in  CNT_W  pitch encoder count
yaw_count  in  CNT_W  yaw encoder count
pitch_duty  out  DUTY_W  pitch PWM duty
pitch_dir  out  1  pitch direction
yaw_duty  out  DUTY_W  yaw PWM duty
yaw_dir  out  1  yaw direction
soft_reset  out  1  one-cycle pulse on reset command
cmd_error  out  1  sticky flag, unknown opcode seen
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, tx_byte=0x00, state IDLE, timeout counter 0, count shadow 0.
  - Reset asserted mid-command discards it.
- Only rx_valid advances the FSM. All register outputs update on the clk edge following the rx_valid cycle (latency 1).
- IDLE opcodes:
  - 0xFF: soft_reset=1 for one cycle; duties, dirs and cmd_error cleared; stay IDLE.
  - 0x11: -> P_DIR.
  - 0x21: -> Y_DIR.
  - 0x12: shadow <= pitch_count; tx_byte <= shadow[15:8]; tx_load; -> GET_HI.
  - 0x22: same as 0x12 but using yaw_count.
  - 0x00: no-op (dummy byte).
  - Any other value: cmd_error <= 1; stay IDLE.
- Set sequence, per axis:
  - DIR: latch rx_byte[0] into a staging dir register; -> HI.
  - HI: stage rx_byte as duty hi.
  - LO: commit staged dir and {hi,lo} duty to outputs in the same cycle (atomic; no partial update visible); -> IDLE.
  - Payload bytes are pure data: 0xFF inside a payload is not a reset.
- Get sequence:
  - GET_HI: on rx_valid (dummy byte clocked while hi byte shifts out), tx_byte <= shadow[7:0]; tx_load; -> GET_LO.
  - GET_LO: on rx_valid, tx_byte <= 0x00; tx_load; -> IDLE.
  - Shadow is frozen for the whole transaction, so hi/lo are coherent even if the count changes.
- Timeout:
  - Counter runs while state != IDLE; cleared on every rx_valid.
  - On reaching TIMEOUT-1: -> IDLE; staged values discarded; tx_byte <= 0x00 with tx_load.
  - If rx_valid arrives in the same cycle as expiry, rx_valid wins and the counter clears.
- tx_load is never asserted in IDLE except on a 0x12/0x22 opcode or a timeout.
- Counts narrower than 16 bits are zero-extended. Duty truncation keeps the lower DUTY_W bits.

Optional Feature:
DUTY_CLAMP_EN
- Defined: at commit, a duty value > MAX_DUTY is written as MAX_DUTY.
- Undefined: the value is written unmodified and MAX_DUTY is ignored.

Test Plan:
- Reset then set: rst_n low mid-stream, release; bytes 0xFF,0x11,0x01,0x01,0x40 -> soft_reset pulse once; after the 5th byte pitch_dir=1, pitch_duty=0x0140; yaw outputs unchanged at 0.
- Pitch readback: pitch_count=0x1234; send 0x12; change count to 0x9999; send 0x00,0x00 -> tx_byte sequence 0x12, 0x34, 0x00, each with tx_load one cycle after rx_valid.
- Payload 0xFF: bytes 0x21,0x00,0xFF,0xFF -> yaw_dir=0, yaw_duty=0xFFFF, no soft_reset; with DUTY_CLAMP_EN and MAX_DUTY=0x0FA0, yaw_duty=0x0FA0.
- Atomic commit and timeout: bytes 0x11,0x01,0x02, then TIMEOUT idle cycles -> busy drops, pitch_duty/dir keep previous values; next 0x22 starts a normal yaw readback.
- Timeout race: with TIMEOUT=8, deliver the next byte exactly on cycle 7 -> no abort, command completes.
- Unknown opcode: byte 0x37 -> cmd_error=1 and stays 1; state IDLE; the next 0xFF clears it.
